// File: rtl/spi_master_cfg.sv
// Full-duplex SPI master: shifts a DATA_W-bit word out on MOSI while capturing MISO,
// with run-time CPOL/CPHA, a fixed SCLK divider, selectable bit order and an owned CS_N.
module spi_master_cfg #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              CPOL,
    input  logic              CPHA,
    input  logic [DATA_W-1:0] DIN,
    input  logic              MISO,
    output logic              BUSY,
    output logic              DONE,
    output logic [DATA_W-1:0] DOUT,
    output logic              MOSI,
    output logic              SCLK,
    output logic              CS_N
);

    localparam int HC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BC_W = $clog2(DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LEAD,
        S_TRAIL,
        S_HOLD,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [HC_W-1:0]   r_hcnt;
    logic [BC_W-1:0]   r_bcnt;
    logic              r_cpol;
    logic              r_cpha;
    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;

    logic              w_half_end;
    logic              w_din_bit;
    logic [DATA_W-1:0] w_din_shifted;
    logic              w_tx_bit;
    logic [DATA_W-1:0] w_tx_shifted;
    logic [DATA_W-1:0] w_rx_shifted;

    assign w_half_end = (r_hcnt == HC_LAST);

    // r_tx always holds the bits still to be sent, next one at the shift-out end.
    assign w_din_bit     = MSB_FIRST ? DIN[DATA_W-1] : DIN[0];
    assign w_din_shifted = MSB_FIRST ? {DIN[DATA_W-2:0], 1'b0} : {1'b0, DIN[DATA_W-1:1]};
    assign w_tx_bit      = MSB_FIRST ? r_tx[DATA_W-1] : r_tx[0];
    assign w_tx_shifted  = MSB_FIRST ? {r_tx[DATA_W-2:0], 1'b0} : {1'b0, r_tx[DATA_W-1:1]};
    assign w_rx_shifted  = MSB_FIRST ? {r_rx[DATA_W-2:0], MISO} : {MISO, r_rx[DATA_W-1:1]};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_hcnt  <= '0;
            r_bcnt  <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            DOUT    <= '0;
            MOSI    <= 1'b0;
            SCLK    <= 1'b0;
            CS_N    <= 1'b1;
        end else begin
            DONE <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    CS_N <= 1'b1;
                    BUSY <= 1'b0;
                    SCLK <= r_cpol;
                    if (START) begin
                        r_cpol  <= CPOL;
                        r_cpha  <= CPHA;
                        r_hcnt  <= '0;
                        r_bcnt  <= '0;
                        r_rx    <= '0;
                        CS_N    <= 1'b0;
                        BUSY    <= 1'b1;
                        SCLK    <= CPOL;
                        r_state <= S_SETUP;
                        // CPHA=0 devices sample on the first edge, so bit 0 must be on the wire now.
                        if (!CPHA) begin
                            MOSI <= w_din_bit;
                            r_tx <= w_din_shifted;
                        end else begin
                            r_tx <= DIN;
                        end
                    end
                end

                S_SETUP: begin
                    if (w_half_end) begin
                        r_hcnt  <= '0;
                        SCLK    <= ~r_cpol;
                        r_state <= S_LEAD;
                        if (r_cpha) begin
                            MOSI <= w_tx_bit;
                            r_tx <= w_tx_shifted;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                S_LEAD: begin
                    if (w_half_end) begin
                        r_hcnt  <= '0;
                        SCLK    <= r_cpol;
                        r_state <= S_TRAIL;
                        if (!r_cpha) begin
                            r_rx <= w_rx_shifted;
                            if (r_bcnt != BC_LAST) begin
                                MOSI <= w_tx_bit;
                                r_tx <= w_tx_shifted;
                            end
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                S_TRAIL: begin
                    if (w_half_end) begin
                        r_hcnt <= '0;
                        if (r_cpha) begin
                            r_rx <= w_rx_shifted;
                        end
                        if (r_bcnt == BC_LAST) begin
                            r_bcnt  <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_bcnt  <= r_bcnt + 1'b1;
                            SCLK    <= ~r_cpol;
                            r_state <= S_LEAD;
                            if (r_cpha) begin
                                MOSI <= w_tx_bit;
                                r_tx <= w_tx_shifted;
                            end
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (w_half_end) begin
                        r_hcnt  <= '0;
                        CS_N    <= 1'b1;
                        DONE    <= 1'b1;
                        DOUT    <= r_rx;
                        MOSI    <= 1'b0;
                        r_state <= S_FIN;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end

                S_FIN: begin
                    BUSY    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Bench for spi_master_cfg: an 8-bit MSB-first instance and a 16-bit LSB-first instance,
// each driven by a simple SPI slave model and checked against word-level expectations.
`timescale 1ns/1ps
module tb_spi_master_cfg;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RST_N;
    logic        START0, START1;
    logic        CPOL, CPHA;
    logic [15:0] DIN;
    logic        LOOP, DEV_BIT;
    logic        MISO0, MISO1;

    logic        BUSY0, DONE0, MOSI0, SCLK0, CSN0;
    logic [7:0]  DOUT0;
    logic        BUSY1, DONE1, MOSI1, SCLK1, CSN1;
    logic [15:0] DOUT1;

    assign MISO0 = LOOP ? MOSI0 : DEV_BIT;
    assign MISO1 = LOOP ? MOSI1 : DEV_BIT;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .MSB_FIRST(1'b1)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .START(START0), .CPOL(CPOL), .CPHA(CPHA),
        .DIN(DIN[7:0]), .MISO(MISO0), .BUSY(BUSY0), .DONE(DONE0), .DOUT(DOUT0),
        .MOSI(MOSI0), .SCLK(SCLK0), .CS_N(CSN0)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(4), .MSB_FIRST(1'b0)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .START(START1), .CPOL(CPOL), .CPHA(CPHA),
        .DIN(DIN), .MISO(MISO1), .BUSY(BUSY1), .DONE(DONE1), .DOUT(DOUT1),
        .MOSI(MOSI1), .SCLK(SCLK1), .CS_N(CSN1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent transfer observed by xfer().
    logic [15:0] x_mosi_word, x_dout;
    int          x_lead, x_trail, x_lat, x_half_min, x_half_max, x_busy_low, x_cs_high;
    bit          x_timeout;
    logic        x_pre_csn, x_pre_busy, x_pre_done, x_fin_csn, x_fin_mosi;

    function automatic int dw(input bit sel); return sel ? 16 : 8; endfunction
    function automatic int cd(input bit sel); return sel ? 4 : 2; endfunction
    function automatic bit msbf(input bit sel); return sel ? 1'b0 : 1'b1; endfunction
    function automatic int lat_exp(input bit sel); return 2 + cd(sel) * (2 * dw(sel) + 2); endfunction
    function automatic logic [15:0] mask(input logic [15:0] v, input bit sel);
        return sel ? v : {8'h00, v[7:0]};
    endfunction
    // k-th bit on the wire for a word, in the instance's bit order
    function automatic logic wire_bit(input logic [15:0] word, input int k, input bit sel);
        if (k >= dw(sel)) return 1'b0;
        return msbf(sel) ? word[dw(sel)-1-k] : word[k];
    endfunction

    function automatic logic o_sclk(input bit sel); return sel ? SCLK1 : SCLK0; endfunction
    function automatic logic o_csn(input bit sel);  return sel ? CSN1  : CSN0;  endfunction
    function automatic logic o_mosi(input bit sel); return sel ? MOSI1 : MOSI0; endfunction
    function automatic logic o_busy(input bit sel); return sel ? BUSY1 : BUSY0; endfunction
    function automatic logic o_done(input bit sel); return sel ? DONE1 : DONE0; endfunction
    function automatic logic [15:0] o_dout(input bit sel); return sel ? DOUT1 : {8'h00, DOUT0}; endfunction

    // Runs one transfer. The slave launches its next bit on the edge opposite to the sampling edge.
    task automatic xfer(input bit sel, input bit p, input bit h, input logic [15:0] w,
                        input logic [15:0] dev, input bit lb, input bit hold_start, input int repulse_n);
        int   n, limit, last_edge;
        logic ps, pc, s, c, is_lead;
        logic seen[$];
        @(negedge CLK);
        x_pre_csn  = o_csn(sel);
        x_pre_busy = o_busy(sel);
        x_pre_done = o_done(sel);
        CPOL = p; CPHA = h; DIN = w; LOOP = lb;
        DEV_BIT = wire_bit(dev, 0, sel);
        if (sel) START1 = 1'b1; else START0 = 1'b1;
        x_lead = 0; x_trail = 0; x_lat = 0; x_half_min = 1000000; x_half_max = 0;
        x_busy_low = 0; x_cs_high = 0; x_timeout = 1'b0; x_mosi_word = '0; x_dout = '0;
        x_fin_csn = 1'b0; x_fin_mosi = 1'b1;
        ps = o_sclk(sel); pc = o_csn(sel);
        limit = lat_exp(sel) + 20;
        last_edge = -1; n = 0;
        seen.delete();
        while (1) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                if (!hold_start) begin START0 = 1'b0; START1 = 1'b0; end
                CPOL = 1'($urandom); CPHA = 1'($urandom); DIN = 16'($urandom);
            end
            if (n == repulse_n) begin if (sel) START1 = 1'b1; else START0 = 1'b1; end
            if (n == repulse_n + 1) begin START0 = 1'b0; START1 = 1'b0; end
            s = o_sclk(sel); c = o_csn(sel);
            if (c === 1'b0 && pc === 1'b0 && s !== ps) begin
                is_lead = (s !== p);
                if (is_lead) x_lead++; else x_trail++;
                if (last_edge >= 0) begin
                    if (n - last_edge < x_half_min) x_half_min = n - last_edge;
                    if (n - last_edge > x_half_max) x_half_max = n - last_edge;
                end
                last_edge = n;
                if (is_lead == !h) seen.push_back(o_mosi(sel));
                if (!h && !is_lead) DEV_BIT = wire_bit(dev, x_trail, sel);
                if (h && is_lead)   DEV_BIT = wire_bit(dev, x_lead - 1, sel);
            end
            if (o_busy(sel) !== 1'b1) x_busy_low++;
            if (o_done(sel) === 1'b1) begin
                x_lat = n + 1;  // counted inclusively from the START-sampling cycle
                x_fin_csn = c; x_fin_mosi = o_mosi(sel); x_dout = o_dout(sel);
                break;
            end
            if (c !== 1'b0) x_cs_high++;
            pc = c; ps = s;
            if (n >= limit) begin x_timeout = 1'b1; break; end
        end
        for (int k = 0; k < seen.size() && k < dw(sel); k++) begin
            x_mosi_word[msbf(sel) ? dw(sel)-1-k : k] = seen[k];
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; START0 = 1'b0; START1 = 1'b0; CPOL = 1'b0; CPHA = 1'b0;
        DIN = '0; LOOP = 1'b0; DEV_BIT = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if ({BUSY0, DONE0, MOSI0, SCLK0, CSN0} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_ctl0: got %b, expected 00001", {BUSY0, DONE0, MOSI0, SCLK0, CSN0});
        end
        n_checks++;
        if ({BUSY1, DONE1, MOSI1, SCLK1, CSN1} !== 5'b00001) begin
            n_fail++; $display("FAIL reset_ctl1: got %b, expected 00001", {BUSY1, DONE1, MOSI1, SCLK1, CSN1});
        end
        n_checks++;
        if (DOUT0 !== 8'h00 || DOUT1 !== 16'h0000) begin
            n_fail++; $display("FAIL reset_dout: got %h/%h, expected 0/0", DOUT0, DOUT1);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        n_checks++;
        if (CSN0 !== 1'b1 || SCLK0 !== 1'b0 || BUSY0 !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: got csn=%b sclk=%b busy=%b, expected 1 0 0", CSN0, SCLK0, BUSY0);
        end
    endtask

    task automatic test_mode0_loop();
        xfer(1'b0, 1'b0, 1'b0, 16'h00A5, 16'h0000, 1'b1, 1'b0, -10);
        n_checks++;
        if (x_timeout || x_lat !== 38) begin n_fail++; $display("FAIL m0_latency: got %0d (timeout=%0d), expected 38", x_lat, x_timeout); end
        n_checks++;
        if (x_dout !== 16'h00A5) begin n_fail++; $display("FAIL m0_dout: got %h, expected a5", x_dout); end
        n_checks++;
        if (x_mosi_word !== 16'h00A5) begin n_fail++; $display("FAIL m0_mosi: got %h, expected a5", x_mosi_word); end
        n_checks++;
        if (x_lead !== 8 || x_trail !== 8) begin n_fail++; $display("FAIL m0_edges: got %0d/%0d, expected 8/8", x_lead, x_trail); end
        n_checks++;
        if (x_busy_low !== 0 || x_cs_high !== 0) begin
            n_fail++; $display("FAIL m0_busy_cs: got busy_low=%0d cs_high=%0d, expected 0 0", x_busy_low, x_cs_high);
        end
        n_checks++;
        if (x_fin_csn !== 1'b1 || x_fin_mosi !== 1'b0) begin
            n_fail++; $display("FAIL m0_fin: got csn=%b mosi=%b, expected 1 0", x_fin_csn, x_fin_mosi);
        end
    endtask

    task automatic test_mode3_model();
        xfer(1'b0, 1'b1, 1'b1, 16'h003C, 16'h00C3, 1'b0, 1'b0, -10);
        n_checks++;
        if (x_mosi_word !== 16'h003C) begin n_fail++; $display("FAIL m3_mosi: got %h, expected 3c", x_mosi_word); end
        n_checks++;
        if (x_dout !== 16'h00C3) begin n_fail++; $display("FAIL m3_dout: got %h, expected c3", x_dout); end
        n_checks++;
        if (x_timeout || x_lat !== 38 || x_lead !== 8 || x_trail !== 8) begin
            n_fail++; $display("FAIL m3_timing: got lat=%0d edges=%0d/%0d, expected 38 8/8", x_lat, x_lead, x_trail);
        end
        @(negedge CLK);
        n_checks++;
        if (SCLK0 !== 1'b1 || CSN0 !== 1'b1 || BUSY0 !== 1'b0 || DONE0 !== 1'b0) begin
            n_fail++; $display("FAIL m3_idle: got sclk=%b csn=%b busy=%b done=%b, expected 1 1 0 0", SCLK0, CSN0, BUSY0, DONE0);
        end
    endtask

    task automatic test_wide_lsb();
        xfer(1'b1, 1'b0, 1'b0, 16'h8001, 16'h0000, 1'b1, 1'b0, -10);
        n_checks++;
        if (x_dout !== 16'h8001) begin n_fail++; $display("FAIL w16_dout: got %h, expected 8001", x_dout); end
        n_checks++;
        if (x_timeout || x_lat !== 138) begin n_fail++; $display("FAIL w16_latency: got %0d, expected 138", x_lat); end
        n_checks++;
        if (x_half_min !== 4 || x_half_max !== 4) begin
            n_fail++; $display("FAIL w16_half: got %0d..%0d, expected 4..4", x_half_min, x_half_max);
        end
        n_checks++;
        if (x_lead !== 16 || x_trail !== 16) begin n_fail++; $display("FAIL w16_edges: got %0d/%0d, expected 16/16", x_lead, x_trail); end
        xfer(1'b1, 1'b1, 1'b1, 16'h0013, 16'hB200, 1'b0, 1'b0, -10);
        n_checks++;
        if (x_mosi_word !== 16'h0013 || x_dout !== 16'hB200) begin
            n_fail++; $display("FAIL w16_order: got mosi=%h dout=%h, expected 0013 b200", x_mosi_word, x_dout);
        end
    endtask

    task automatic test_restart_ignored();
        logic [15:0] dv;
        int dones, cs_low;
        dv = mask(16'($urandom), 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 16'($urandom), dv, 1'b0, 1'b0, 15);
        n_checks++;
        if (x_timeout || x_lat !== 38 || x_dout !== dv) begin
            n_fail++; $display("FAIL restart_first: got lat=%0d dout=%h, expected 38 %h", x_lat, x_dout, dv);
        end
        dones = 0; cs_low = 0;
        repeat (60) begin
            @(negedge CLK);
            if (DONE0 === 1'b1) dones++;
            if (CSN0 !== 1'b1) cs_low++;
        end
        n_checks++;
        if (dones !== 0 || cs_low !== 0) begin
            n_fail++; $display("FAIL restart_ignored: got dones=%0d cs_low=%0d, expected 0 0", dones, cs_low);
        end
        n_checks++;
        if ({8'h00, DOUT0} !== dv) begin n_fail++; $display("FAIL restart_dout_held: got %h, expected %h", DOUT0, dv); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] dv;
        int dones;
        @(negedge CLK);
        CPOL = 1'b1; CPHA = 1'b0; DIN = 16'h005A; LOOP = 1'b0; START0 = 1'b1;
        @(negedge CLK);
        START0 = 1'b0;
        repeat (18) @(negedge CLK);
        n_checks++;
        if (CSN0 !== 1'b0 || BUSY0 !== 1'b1) begin
            n_fail++; $display("FAIL abort_active: got csn=%b busy=%b, expected 0 1", CSN0, BUSY0);
        end
        #2 RST_N = 1'b0;
        #1;
        n_checks++;
        if ({BUSY0, DONE0, MOSI0, SCLK0, CSN0} !== 5'b00001 || DOUT0 !== 8'h00) begin
            n_fail++; $display("FAIL abort_async: got %b dout=%h, expected 00001 dout=00", {BUSY0, DONE0, MOSI0, SCLK0, CSN0}, DOUT0);
        end
        dones = 0;
        repeat (3) begin @(negedge CLK); if (DONE0 === 1'b1) dones++; end
        RST_N = 1'b1;
        repeat (3) begin @(negedge CLK); if (DONE0 === 1'b1) dones++; end
        n_checks++;
        if (dones !== 0 || SCLK0 !== 1'b0 || CSN0 !== 1'b1) begin
            n_fail++; $display("FAIL abort_no_done: got dones=%0d sclk=%b csn=%b, expected 0 0 1", dones, SCLK0, CSN0);
        end
        dv = mask(16'($urandom), 1'b0);
        xfer(1'b0, 1'b0, 1'b0, 16'h0096, dv, 1'b0, 1'b0, -10);
        n_checks++;
        if (x_timeout || x_lat !== 38 || x_dout !== dv || x_mosi_word !== 16'h0096) begin
            n_fail++; $display("FAIL abort_recover: got lat=%0d dout=%h mosi=%h, expected 38 %h 0096", x_lat, x_dout, x_mosi_word, dv);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dv, wv;
        logic        prev_fin_csn;
        int          gap_cs;
        prev_fin_csn = 1'b0;
        for (int t = 0; t < 3; t++) begin
            dv = mask(16'($urandom), 1'b0);
            wv = mask(16'($urandom), 1'b0);
            xfer(1'b0, 1'b0, 1'b1, wv, dv, 1'b0, 1'b1, -10);
            n_checks++;
            if (x_timeout || x_lat !== 38 || x_dout !== dv || x_mosi_word !== wv) begin
                n_fail++; $display("FAIL b2b_xfer%0d: got lat=%0d dout=%h mosi=%h, expected 38 %h %h", t, x_lat, x_dout, x_mosi_word, dv, wv);
            end
            if (t > 0) begin
                gap_cs = (prev_fin_csn === 1'b1 ? 1 : 0) + (x_pre_csn === 1'b1 ? 1 : 0);
                n_checks++;
                if (gap_cs < 2 || x_pre_busy !== 1'b0 || x_pre_done !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_gap%0d: got cs_high=%0d busy=%b done=%b, expected 2 0 0", t, gap_cs, x_pre_busy, x_pre_done);
                end
            end
            prev_fin_csn = x_fin_csn;
        end
        START0 = 1'b0;
        repeat (3) @(negedge CLK);
        n_checks++;
        if (CSN0 !== 1'b1 || BUSY0 !== 1'b0) begin
            n_fail++; $display("FAIL b2b_stop: got csn=%b busy=%b, expected 1 0", CSN0, BUSY0);
        end
    endtask

    task automatic test_random();
        bit          sel, p, h, lb;
        logic [15:0] wv, dv, exp_rx;
        for (int i = 0; i < 12; i++) begin
            sel = 1'($urandom); p = 1'($urandom); h = 1'($urandom); lb = 1'($urandom);
            wv = mask(16'($urandom), sel);
            dv = mask(16'($urandom), sel);
            exp_rx = lb ? wv : dv;
            xfer(sel, p, h, wv, dv, lb, 1'b0, -10);
            n_checks++;
            if (x_timeout || x_lat !== lat_exp(sel)) begin
                n_fail++; $display("FAIL rnd%0d_latency: got %0d, expected %0d", i, x_lat, lat_exp(sel));
            end
            n_checks++;
            if (x_dout !== exp_rx || x_mosi_word !== wv) begin
                n_fail++; $display("FAIL rnd%0d_data: got dout=%h mosi=%h, expected %h %h (sel=%0d mode=%0d%0d)",
                                   i, x_dout, x_mosi_word, exp_rx, wv, sel, p, h);
            end
            n_checks++;
            if (x_lead !== dw(sel) || x_trail !== dw(sel) || x_half_min !== cd(sel) || x_half_max !== cd(sel)) begin
                n_fail++; $display("FAIL rnd%0d_sclk: got edges=%0d/%0d half=%0d..%0d, expected %0d %0d",
                                   i, x_lead, x_trail, x_half_min, x_half_max, dw(sel), cd(sel));
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0_loop();
        test_mode3_model();
        test_wide_lsb();
        test_restart_ignored();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
